// File: rtl/bec_slave_if_if.sv
// Controller<->BEC bus: operand write channel, run request, serial key handshake and result return.
interface bec_slave_if_if #(
  parameter int unsigned W = 163
);
  logic         load_data;
  logic         trigLoad;
  logic [2:0]   load_status;
  logic [W-1:0] data_in;
  logic         master_ena_proc;
  logic         ki;
  logic         next_key;
  logic         slv_done;
  logic [3:0]   becStatus;
  logic [W-1:0] data_out;

  modport master (
    output load_data, trigLoad, load_status, data_in, master_ena_proc, ki,
    input  next_key, slv_done, becStatus, data_out
  );

  modport slave (
    input  load_data, trigLoad, load_status, data_in, master_ena_proc, ki,
    output next_key, slv_done, becStatus, data_out
  );
endinterface

// File: rtl/bec_slave_if.sv
// BEC-side bus endpoint: captures six operands, streams the key bit-serially into the
// ladder core, and returns the core result to the controller.
module bec_slave_if #(
  parameter int unsigned W        = 163,
  parameter int unsigned KEY_BITS = 163
) (
  input  logic         clk,
  input  logic         rst,
  bec_slave_if_if.slave bus,
  output logic [W-1:0] op_w1,
  output logic [W-1:0] op_z1,
  output logic [W-1:0] op_w2,
  output logic [W-1:0] op_z2,
  output logic [W-1:0] op_inv_w0,
  output logic [W-1:0] op_d,
  output logic         core_init,
  output logic         core_step,
  output logic         core_bit,
  input  logic         core_step_done,
  input  logic         core_done,
  input  logic [W-1:0] core_result
);
  localparam int unsigned CW = $clog2(KEY_BITS + 1);

  typedef enum logic [3:0] {
    IDLE  = 4'h0,
    LOAD  = 4'h1,
    ARM   = 4'h2,
    KEY   = 4'h3,
    KWAIT = 4'h4,
    CORE  = 4'h5,
    DONE  = 4'h6,
    ERR   = 4'hF
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    mask_q, mask_d;
  logic [W-1:0]  op_reg_q [6];
  logic [W-1:0]  op_reg_d [6];
  logic          trig_q, ld_q;
  logic          next_key_q, next_key_d;
  logic          core_init_q, core_init_d;
  logic          core_step_q, core_step_d;
  logic          core_bit_q, core_bit_d;
  logic          slv_done_q, slv_done_d;
  logic [W-1:0]  data_out_q, data_out_d;
  logic          trig_edge, ld_rise, capture, abort;

  always_comb begin
    trig_edge = bus.trigLoad & ~trig_q;
    ld_rise   = bus.load_data & ~ld_q;
    capture   = (state_q == LOAD) && trig_edge && bus.load_data && (bus.load_status <= 3'd5);
    abort     = !bus.master_ena_proc &&
                ((state_q == ARM) || (state_q == KEY) || (state_q == KWAIT) || (state_q == CORE));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    op_reg_d   = op_reg_q;
    slv_done_d = slv_done_q;
    data_out_d = data_out_q;

    for (int unsigned i = 0; i < 6; i++) begin
      if (capture && (bus.load_status == 3'(i))) begin
        op_reg_d[i] = bus.data_in;
        mask_d[i]   = 1'b1;
      end
    end

    // Abort outranks any same-cycle core_step_done/core_done.
    if (abort) begin
      state_d = IDLE;
      mask_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (ld_rise) begin
          state_d    = LOAD;
          slv_done_d = 1'b0;
          data_out_d = '0;
          mask_d     = '0;
        end
        LOAD: if (bus.master_ena_proc) begin
          state_d = (mask_q == 6'h3F) ? ARM : ERR;
        end
        ARM: begin
          cnt_d   = '0;
          state_d = KEY;
        end
        KEY: state_d = KWAIT;
        KWAIT: if (core_step_done) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CW'(KEY_BITS - 1)) ? CORE : KEY;
        end
        CORE: if (core_done) begin
          data_out_d = core_result;
          slv_done_d = 1'b1;
          state_d    = DONE;
        end
        DONE: if (ld_rise) begin
          state_d    = LOAD;
          slv_done_d = 1'b0;
          mask_d     = '0;
        end
        ERR: begin
          slv_done_d = 1'b0;
          if (!bus.master_ena_proc) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Pulses are registered from the next state so they line up with the KEY/ARM cycle.
    next_key_d  = (state_d == KEY);
    core_step_d = (state_d == KEY);
    core_init_d = (state_d == ARM);
    core_bit_d  = (state_d == KEY) ? bus.ki : core_bit_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      trig_q      <= 1'b0;
      ld_q        <= 1'b0;
      next_key_q  <= 1'b0;
      core_init_q <= 1'b0;
      core_step_q <= 1'b0;
      core_bit_q  <= 1'b0;
      slv_done_q  <= 1'b0;
      data_out_q  <= '0;
      for (int unsigned i = 0; i < 6; i++) op_reg_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      trig_q      <= bus.trigLoad;
      ld_q        <= bus.load_data;
      next_key_q  <= next_key_d;
      core_init_q <= core_init_d;
      core_step_q <= core_step_d;
      core_bit_q  <= core_bit_d;
      slv_done_q  <= slv_done_d;
      data_out_q  <= data_out_d;
      op_reg_q    <= op_reg_d;
    end
  end

  assign bus.next_key  = next_key_q;
  assign bus.slv_done  = slv_done_q;
  assign bus.becStatus = state_q;
  assign bus.data_out  = data_out_q;
  assign core_init     = core_init_q;
  assign core_step     = core_step_q;
  assign core_bit      = core_bit_q;
  assign op_w1         = op_reg_q[0];
  assign op_z1         = op_reg_q[1];
  assign op_w2         = op_reg_q[2];
  assign op_z2         = op_reg_q[3];
  assign op_inv_w0     = op_reg_q[4];
  assign op_d          = op_reg_q[5];
endmodule

// File: tb/tb_bec_slave_if.sv
// Bench for bec_slave_if: table-driven operand loads, scoreboarded key stream,
// plus hand sequences for error, abort and asynchronous reset.
module tb_bec_slave_if;
  localparam int unsigned W  = 163;
  localparam int unsigned KB = 163;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] op_w1, op_z1, op_w2, op_z2, op_inv_w0, op_d;
  logic         core_init, core_step, core_bit;
  logic         core_step_done;
  logic         core_done;
  logic [W-1:0] core_result;

  logic [W-1:0] key_sr = '0;
  logic [W-1:0] key_val;
  logic         key_load;

  int unsigned  errors = 0;
  int unsigned  checks = 0;
  int unsigned  nk_count = 0;
  logic         nk_prev = 1'b0;
  logic         exp_bits [$];
  logic [W-1:0] exp_ops [6];

  typedef struct {
    logic         ld;
    logic [2:0]   slot;
    logic [W-1:0] data;
    int unsigned  hold;
  } vec_t;
  vec_t vecs [13];

  bec_slave_if_if #(.W(W)) bus ();

  bec_slave_if #(.W(W), .KEY_BITS(KB)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .op_w1          (op_w1),
    .op_z1          (op_z1),
    .op_w2          (op_w2),
    .op_z2          (op_z2),
    .op_inv_w0      (op_inv_w0),
    .op_d           (op_d),
    .core_init      (core_init),
    .core_step      (core_step),
    .core_bit       (core_bit),
    .core_step_done (core_step_done),
    .core_done      (core_done),
    .core_result    (core_result)
  );

  always #5 clk = ~clk;

  // Controller key shift register and core step responder.
  assign bus.ki = key_sr[0];
  always @(posedge clk) begin
    if (key_load) key_sr <= key_val;
    else if (bus.next_key) key_sr <= key_sr >> 1;
    core_step_done <= core_step;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] get_op(input int unsigned i);
    case (i)
      0: return op_w1;
      1: return op_z1;
      2: return op_w2;
      3: return op_z2;
      4: return op_inv_w0;
      default: return op_d;
    endcase
  endfunction

  // Scoreboard consumer: each core step must carry the next expected key bit.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.next_key) begin
        nk_count++;
        chk("next_key_gap", W'(nk_prev), W'(1'b0));
        chk("step_with_next_key", W'(core_step), W'(1'b1));
      end
      nk_prev = bus.next_key;
      if (core_step) begin
        if (exp_bits.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL core_bit: got %0b expected none (no step expected)", core_bit);
        end else begin
          chk("core_bit", W'(core_bit), W'(exp_bits.pop_front()));
        end
      end
    end
  end

  task automatic wait_status(input logic [3:0] st, input int unsigned maxc, input string nm);
    for (int unsigned i = 0; i < maxc && bus.becStatus !== st; i++) @(negedge clk);
    chk(nm, W'(bus.becStatus), W'(st));
  endtask

  task automatic start_load();
    bus.load_data = 1'b0;
    @(negedge clk);
    bus.load_data = 1'b1;
    @(negedge clk);
    chk("enter_load", W'(bus.becStatus), W'(4'h1));
  endtask

  task automatic trig_slot(input logic [2:0] s, input logic [W-1:0] dat);
    bus.load_status = s;
    bus.data_in     = dat;
    bus.trigLoad    = 1'b1;
    @(negedge clk);
    bus.trigLoad    = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_key(input logic [W-1:0] k, input int unsigned nbits);
    key_val  = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    for (int unsigned i = 0; i < nbits; i++) exp_bits.push_back(k[i]);
  endtask

  initial begin
    int unsigned nk0;
    logic [W-1:0] k;

    vecs[0]  = '{1'b1, 3'd0, W'(1),      1};
    vecs[1]  = '{1'b1, 3'd1, W'(2),      1};
    vecs[2]  = '{1'b1, 3'd2, W'(3),      1};
    vecs[3]  = '{1'b1, 3'd3, W'(4),      1};
    vecs[4]  = '{1'b1, 3'd4, W'(5),      1};
    vecs[5]  = '{1'b0, 3'd5, W'(16'hDEAD), 1};
    vecs[6]  = '{1'b1, 3'd6, W'(8'h77),  1};
    vecs[7]  = '{1'b1, 3'd7, W'(8'h88),  1};
    vecs[8]  = '{1'b1, 3'd5, W'(6),      1};
    vecs[9]  = '{1'b1, 3'd2, W'(8'h33),  5};
    vecs[10] = '{1'b1, 3'd0, W'(8'h99),  1};
    vecs[11] = '{1'b1, 3'd0, W'(1),      1};
    vecs[12] = '{1'b1, 3'd2, W'(3),      1};

    rst = 1'b1;
    bus.load_data = 1'b0;
    bus.trigLoad = 1'b0;
    bus.load_status = '0;
    bus.data_in = '0;
    bus.master_ena_proc = 1'b0;
    key_load = 1'b0;
    key_val = '0;
    core_done = 1'b0;
    core_result = '0;
    for (int i = 0; i < 6; i++) exp_ops[i] = '0;

    repeat (2) @(negedge clk);
    chk("rst_status", W'(bus.becStatus), W'(4'h0));
    chk("rst_slv_done", W'(bus.slv_done), '0);
    chk("rst_next_key", W'(bus.next_key), '0);
    chk("rst_data_out", bus.data_out, '0);
    chk("rst_op_d", op_d, '0);
    rst = 1'b0;

    // Operand loads, ignored triggers, held trigger and rewrites.
    start_load();
    for (int v = 0; v < 13; v++) begin
      bus.load_data   = vecs[v].ld;
      bus.load_status = vecs[v].slot;
      bus.data_in     = vecs[v].data;
      bus.trigLoad    = 1'b1;
      @(negedge clk);
      for (int unsigned h = 1; h < vecs[v].hold; h++) begin
        bus.load_status = 3'd0;
        bus.data_in     = W'(16'hBAD);
        @(negedge clk);
      end
      bus.trigLoad  = 1'b0;
      bus.load_data = 1'b1;
      if (vecs[v].ld && vecs[v].slot <= 3'd5) exp_ops[vecs[v].slot] = vecs[v].data;
      for (int unsigned i = 0; i < 6; i++)
        chk($sformatf("vec%0d_op%0d", v, i), get_op(i), exp_ops[i]);
      chk($sformatf("vec%0d_status", v), W'(bus.becStatus), W'(4'h1));
      @(negedge clk);
    end

    // Full run with alternating key 1,0,1,0...
    for (int i = 0; i < int'(W); i++) k[i] = (i % 2 == 0);
    push_key(k, KB);
    nk0 = nk_count;
    bus.master_ena_proc = 1'b1;
    @(negedge clk);
    chk("arm_status", W'(bus.becStatus), W'(4'h2));
    chk("arm_core_init", W'(core_init), W'(1'b1));
    chk("arm_no_next_key", W'(bus.next_key), '0);
    @(negedge clk);
    chk("first_next_key", W'(bus.next_key), W'(1'b1));
    wait_status(4'h5, 700, "reach_core");
    chk("next_key_total", W'(nk_count - nk0), W'(KB));
    chk("bits_consumed", W'(exp_bits.size()), '0);
    core_result = W'(12'hABC);
    core_done   = 1'b1;
    @(negedge clk);
    core_done   = 1'b0;
    chk("done_status", W'(bus.becStatus), W'(4'h6));
    chk("done_slv_done", W'(bus.slv_done), W'(1'b1));
    chk("done_data_out", bus.data_out, W'(12'hABC));
    repeat (3) @(negedge clk);
    chk("done_held", bus.data_out, W'(12'hABC));

    // Incomplete mask -> ERR, then back to IDLE.
    bus.master_ena_proc = 1'b0;
    start_load();
    chk("reload_clears_done", W'(bus.slv_done), '0);
    for (int s = 0; s < 5; s++) trig_slot(3'(s), W'(s + 1));
    bus.master_ena_proc = 1'b1;
    @(negedge clk);
    chk("err_status", W'(bus.becStatus), W'(4'hF));
    chk("err_slv_done", W'(bus.slv_done), '0);
    bus.master_ena_proc = 1'b0;
    @(negedge clk);
    chk("err_to_idle", W'(bus.becStatus), W'(4'h0));

    // Abort after 10 key bits, dropping enable in the cycle core_step_done arrives.
    start_load();
    for (int s = 0; s < 6; s++) trig_slot(3'(s), W'(s + 16));
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    push_key(k, 10);
    nk0 = nk_count;
    bus.master_ena_proc = 1'b1;
    for (int unsigned i = 0; i < 100 && (nk_count - nk0) < 10; i++) begin
      @(negedge clk);
      #1;
    end
    chk("abort_ten_bits", W'(nk_count - nk0), W'(10));
    @(negedge clk);
    chk("abort_in_kwait", W'(bus.becStatus), W'(4'h4));
    bus.master_ena_proc = 1'b0;
    @(negedge clk);
    chk("abort_idle", W'(bus.becStatus), W'(4'h0));
    repeat (20) @(negedge clk);
    chk("abort_no_more_next_key", W'(nk_count - nk0), W'(10));
    chk("abort_slv_done", W'(bus.slv_done), '0);
    chk("abort_still_idle", W'(bus.becStatus), W'(4'h0));

    // Asynchronous reset while waiting for a step.
    start_load();
    for (int s = 0; s < 6; s++) trig_slot(3'(s), W'(s + 32));
    push_key(W'($urandom), 1);
    bus.master_ena_proc = 1'b1;
    wait_status(4'h4, 10, "reach_kwait");
    #2 rst = 1'b1;
    bus.load_data = 1'b0;
    bus.master_ena_proc = 1'b0;
    #1;
    chk("arst_status", W'(bus.becStatus), W'(4'h0));
    chk("arst_op_w1", op_w1, '0);
    chk("arst_op_d", op_d, '0);
    chk("arst_data_out", bus.data_out, '0);
    chk("arst_pulses", W'({bus.next_key, core_step, core_init, bus.slv_done}), '0);
    chk("arst_bits_consumed", W'(exp_bits.size()), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
